regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
Controls the single write port of the 32-entry integer register bank in the pipelined core. It arbitrates between fixed-latency ALU/writeback results and variable-latency memory/cache load returns. It keeps a scoreboard of registers awaiting a memory return and stalls decode on RAW/WAW hazards against them. It also drives the bank's active-low write enable and suppresses writes to x0, because the bank's default decode would otherwise corrupt x31.

Parameters:
MAX_OUTSTANDING, 4, maximum in-flight long-latency (memory) destinations
CNT_W, 3, width of outstanding counter; must hold 0..MAX_OUTSTANDING

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high
issue_valid  input  1  decode presents an instruction
issue_rs1  input  5  source register 1
issue_rs2  input  5  source register 2
issue_rd  input  5  destination register
issue_long  input  1  destination produced by memory return
issue_stall  output  1  decode must hold the instruction this cycle
alu_wb_valid  input  1  ALU writeback request this cycle (cannot be stalled)
alu_wb_rd  input  5  ALU destination
alu_wb_data  input  32  ALU result
mem_wb_valid  input  1  memory return valid
mem_wb_rd  input  5  memory return destination
mem_wb_data  input  32  load data
mem_wb_ready  output  1  memory return accepted when valid&ready
rf_rd  output  5  to bank rd
rf_writeData  output  32  to bank writeData
rf_regWrite  output  1  to bank regWrite, ACTIVE-LOW (0 = write)
busy_mask  output  32  scoreboard, bit0 always 0
outstanding  output  CNT_W  in-flight long destinations

Behaviour:
- State: 1-entry holding buffer (buf_valid, buf_rd, buf_data); busy[31:1]; outstanding counter.
- Reset (async): buf_valid=0, busy=0, outstanding=0.
- While reset is asserted: rf_regWrite=1, rf_rd=0, rf_writeData=0, mem_wb_ready=0, issue_stall=1.
- mem_wb_ready = !buf_valid (combinational).
- Port selection is combinational, priority order:
  1. alu_wb_valid && alu_wb_rd!=0 -> ALU.
  2. buf_valid -> buffer.
  3. mem_wb_valid && mem_wb_ready && mem_wb_rd!=0 -> direct memory write.
  4. Otherwise idle: rf_regWrite=1, rf_rd=0, rf_writeData=0.
- Bank latches the selected write at the next rising edge (0-cycle scheduler latency).
- Accepted memory return with rd!=0 that loses to the ALU -> captured into the buffer at the edge, written the next cycle the ALU port is free.
- Accepted memory return with rd=0 -> discarded; no port use, no counter change.
- Memory commit = buffer write or direct memory write reaching the port. On commit:
  - clear busy[rd];
  - decrement outstanding, saturating at 0 (stale returns after reset never underflow).
- Any write with rd=0 is never driven (rf_regWrite stays 1).
- Hazard: issue_stall = issue_valid && (busy[rs1] || busy[rs2] || busy[rd] || (issue_long && outstanding==MAX_OUTSTANDING)). Index 0 is never busy.
- Accepted long issue (issue_valid && !issue_stall && issue_long && issue_rd!=0):
  - set busy[issue_rd];
  - increment outstanding.
- Same-cycle commit and accepted long issue: counter net unchanged.
  - Commit and set on the same register cannot coincide, because issue stalls on busy[rd] evaluated from current state.
- ALU write to a busy register: write proceeds; busy unaffected.
- The ALU is never backpressured.

Decomposition:
- Shared package: REG_X0 constant, 5-bit register index typedef, RF_WRITE_EN=1'b0 / RF_WRITE_DIS=1'b1 constants for the bank's active-low enable.
- One sub-module, reg_scoreboard: busy bits, outstanding counter, stall logic.
- Arbiter and buffer stay in the top.

Test Plan:
- Reset mid-operation: buffer full, busy[5] set, outstanding=2; pulse reset -> all cleared, rf_regWrite=1; later mem return rd=5 writes x5, outstanding stays 0.
- x0 suppression: alu_wb rd=0 data=0xDEADBEEF -> rf_regWrite=1 every cycle; x31 unchanged.
- Collision: same cycle ALU rd=6 data=0x11 and mem rd=7 data=0x22 -> cycle0 port x6/0x11, mem_wb_ready falls; cycle1 port x7/0x22, busy[7] cleared, ready rises.
- RAW stall: long issue rd=10; next issue rs1=10 -> stall held until mem return x10 commits; stall drops the cycle after commit.
- Counter limit: 4 long issues to x11..x14 accepted; 5th long issue stalls, non-long issue to x15 accepted; one return -> 5th accepted.
- Same-cycle commit and long issue: outstanding=3, commit x11 while long issue rd=20 -> outstanding stays 3, busy[11]=0, busy[20]=1.

Source files
------------

// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types and constants for the register-bank write scheduler.
// The bank's write enable is active-low, hence the named enable/disable levels.
package regfile_write_scheduler_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_X0       = 5'd0;
    localparam logic     RF_WRITE_EN  = 1'b0;
    localparam logic     RF_WRITE_DIS = 1'b1;

endpackage

// File: rtl/regfile_write_scheduler_scoreboard.sv
// Tracks registers waiting on a memory return, counts in-flight long destinations,
// and raises the decode stall on RAW/WAW hazards or a full outstanding window.
module reg_scoreboard
    import regfile_write_scheduler_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic [4:0]       issue_rd,
    input  logic             issue_long,
    input  logic             commit_valid,
    input  logic [4:0]       commit_rd,
    output logic             issue_stall,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] outstanding
);

    logic [31:1]      busy;
    logic [31:0]      busy_upd;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             at_limit;
    logic             hazard;
    logic             accept_long;

    assign busy_mask   = {busy, 1'b0};
    assign outstanding = count;

    assign at_limit    = (count == CNT_W'(MAX_OUTSTANDING));
    assign hazard      = busy_mask[issue_rs1] | busy_mask[issue_rs2] | busy_mask[issue_rd]
                       | (issue_long & at_limit);
    assign issue_stall = reset | (issue_valid & hazard);
    assign accept_long = issue_valid & ~issue_stall & issue_long & (issue_rd != REG_X0);

    // Clear before set: a stale return to a register being re-issued leaves it busy.
    always_comb begin
        busy_upd = busy_mask;
        if (commit_valid)
            busy_upd[commit_rd] = 1'b0;
        if (accept_long)
            busy_upd[issue_rd] = 1'b1;
    end

    // Saturating decrement absorbs returns that were in flight across a reset.
    always_comb begin
        count_next = count;
        if (commit_valid && !accept_long) begin
            if (count != '0)
                count_next = count - 1'b1;
        end else if (accept_long && !commit_valid) begin
            count_next = count + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy  <= '0;
            count <= '0;
        end else begin
            busy  <= busy_upd[31:1];
            count <= count_next;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Single write-port arbiter for the integer register bank: ALU results win,
// memory returns that lose are parked in a one-entry buffer.
module regfile_write_scheduler
    import regfile_write_scheduler_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic [4:0]       issue_rd,
    input  logic             issue_long,
    output logic             issue_stall,
    input  logic             alu_wb_valid,
    input  logic [4:0]       alu_wb_rd,
    input  logic [31:0]      alu_wb_data,
    input  logic             mem_wb_valid,
    input  logic [4:0]       mem_wb_rd,
    input  logic [31:0]      mem_wb_data,
    output logic             mem_wb_ready,
    output logic [4:0]       rf_rd,
    output logic [31:0]      rf_writeData,
    output logic             rf_regWrite,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] outstanding
);

    logic        buf_valid;
    reg_idx_t    buf_rd;
    logic [31:0] buf_data;

    logic        alu_sel;
    logic        buf_sel;
    logic        mem_sel;
    logic        mem_accept;
    logic        capture;
    logic        commit_valid;
    reg_idx_t    commit_rd;

    assign mem_wb_ready = ~reset & ~buf_valid;
    assign mem_accept   = mem_wb_valid & mem_wb_ready;

    always_comb begin
        alu_sel = 1'b0;
        buf_sel = 1'b0;
        mem_sel = 1'b0;
        if (alu_wb_valid && alu_wb_rd != REG_X0)
            alu_sel = 1'b1;
        else if (buf_valid)
            buf_sel = 1'b1;
        else if (mem_accept && mem_wb_rd != REG_X0)
            mem_sel = 1'b1;
    end

    assign capture      = alu_sel & mem_accept & (mem_wb_rd != REG_X0);
    assign commit_valid = ~reset & (buf_sel | mem_sel);
    assign commit_rd    = buf_sel ? buf_rd : mem_wb_rd;

    // x0 never reaches the bank: its default decode would alias onto x31.
    always_comb begin
        rf_regWrite  = RF_WRITE_DIS;
        rf_rd        = REG_X0;
        rf_writeData = '0;
        if (!reset) begin
            if (alu_sel) begin
                rf_regWrite  = RF_WRITE_EN;
                rf_rd        = alu_wb_rd;
                rf_writeData = alu_wb_data;
            end else if (buf_sel) begin
                rf_regWrite  = RF_WRITE_EN;
                rf_rd        = buf_rd;
                rf_writeData = buf_data;
            end else if (mem_sel) begin
                rf_regWrite  = RF_WRITE_EN;
                rf_rd        = mem_wb_rd;
                rf_writeData = mem_wb_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_rd    <= REG_X0;
            buf_data  <= '0;
        end else if (capture) begin
            buf_valid <= 1'b1;
            buf_rd    <= mem_wb_rd;
            buf_data  <= mem_wb_data;
        end else if (buf_sel) begin
            buf_valid <= 1'b0;
        end
    end

    reg_scoreboard #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CNT_W          (CNT_W)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .issue_long  (issue_long),
        .commit_valid(commit_valid),
        .commit_rd   (commit_rd),
        .issue_stall (issue_stall),
        .busy_mask   (busy_mask),
        .outstanding (outstanding)
    );

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_regfile_write_scheduler;

    localparam int MAXO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid, issue_long;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        alu_wb_valid, mem_wb_valid;
    logic [4:0]  alu_wb_rd, mem_wb_rd;
    logic [31:0] alu_wb_data, mem_wb_data;
    logic        issue_stall, mem_wb_ready, rf_regWrite;
    logic [4:0]  rf_rd;
    logic [31:0] rf_writeData, busy_mask;
    logic [2:0]  outstanding;

    int n_vec = 0;
    int n_err = 0;

    regfile_write_scheduler #(.MAX_OUTSTANDING(MAXO), .CNT_W(3)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_long(issue_long), .issue_stall(issue_stall),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
        .mem_wb_ready(mem_wb_ready), .rf_rd(rf_rd), .rf_writeData(rf_writeData),
        .rf_regWrite(rf_regWrite), .busy_mask(busy_mask), .outstanding(outstanding)
    );

    always #5 clock = ~clock;

    // Reference model: set of pending registers, a count, and a FIFO of parked returns.
    logic [31:0] m_busy;
    int          m_cnt;
    logic [36:0] m_pend[$];

    logic        e_regwrite, e_ready, e_stall;
    logic [4:0]  e_rd, e_crd;
    logic [31:0] e_data;
    bit          e_commit, e_from_buf, e_cap, e_acc_long;

    function automatic void model_reset();
        m_busy = '0;
        m_cnt  = 0;
        m_pend.delete();
    endfunction

    function automatic void predict();
        bit mem_acc;
        e_ready    = (m_pend.size() == 0);
        mem_acc    = mem_wb_valid && e_ready;
        e_regwrite = 1'b1; e_rd = '0; e_data = '0; e_crd = '0;
        e_commit = 0; e_from_buf = 0; e_cap = 0;
        if (alu_wb_valid && alu_wb_rd != 0) begin
            e_regwrite = 1'b0; e_rd = alu_wb_rd; e_data = alu_wb_data;
            e_cap = mem_acc && mem_wb_rd != 0;
        end else if (m_pend.size() != 0) begin
            e_regwrite = 1'b0; e_rd = m_pend[0][36:32]; e_data = m_pend[0][31:0];
            e_commit = 1; e_from_buf = 1; e_crd = e_rd;
        end else if (mem_acc && mem_wb_rd != 0) begin
            e_regwrite = 1'b0; e_rd = mem_wb_rd; e_data = mem_wb_data;
            e_commit = 1; e_crd = e_rd;
        end
        e_stall = issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] || m_busy[issue_rd]
                  || (issue_long && m_cnt == MAXO));
        e_acc_long = issue_valid && !e_stall && issue_long && issue_rd != 0;
    endfunction

    task automatic advance();
        predict();
        @(posedge clock);
        if (e_from_buf) void'(m_pend.pop_front());
        if (e_cap) m_pend.push_back({mem_wb_rd, mem_wb_data});
        if (e_commit) m_busy[e_crd] = 1'b0;
        if (e_acc_long) m_busy[issue_rd] = 1'b1;
        if (e_commit && !e_acc_long) begin
            if (m_cnt > 0) m_cnt--;
        end else if (e_acc_long && !e_commit) begin
            m_cnt++;
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_long = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        mem_wb_valid = 0; mem_wb_rd = 0; mem_wb_data = 0;
    endtask

    task automatic set_issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic lng);
        issue_valid = 1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_long = lng;
    endtask

    task automatic set_mem(input logic [4:0] rd, input logic [31:0] data);
        mem_wb_valid = 1; mem_wb_rd = rd; mem_wb_data = data;
    endtask

    task automatic test_reset();
        idle();
        alu_wb_valid = 1; alu_wb_rd = 5'd4; alu_wb_data = 32'h1234;
        set_mem(5'd9, 32'h99);
        #1;
        n_vec++; if (rf_regWrite !== 1'b1) begin n_err++; $display("FAIL rst_regwrite: got %b want 1", rf_regWrite); end
        n_vec++; if (rf_rd !== 5'd0 || rf_writeData !== 32'd0) begin n_err++; $display("FAIL rst_port: got %0d/%h want 0/0", rf_rd, rf_writeData); end
        n_vec++; if (mem_wb_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", mem_wb_ready); end
        n_vec++; if (issue_stall !== 1'b1) begin n_err++; $display("FAIL rst_stall: got %b want 1", issue_stall); end
        n_vec++; if (busy_mask !== 32'd0 || outstanding !== 3'd0) begin n_err++; $display("FAIL rst_state: got %h/%0d want 0/0", busy_mask, outstanding); end
        @(negedge clock);
        idle();
        reset = 0;
        model_reset();
        #1;
        n_vec++; if (mem_wb_ready !== 1'b1 || issue_stall !== 1'b0) begin n_err++; $display("FAIL rst_release: got ready %b stall %b want 1/0", mem_wb_ready, issue_stall); end
        advance();
    endtask

    task automatic test_x0_suppress();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); idle();
            alu_wb_valid = 1; alu_wb_rd = 5'd0; alu_wb_data = 32'hDEADBEEF;
            #1;
            n_vec++; if (rf_regWrite !== 1'b1 || rf_rd !== 5'd0) begin n_err++; $display("FAIL x0_alu: got we %b rd %0d want 1/0", rf_regWrite, rf_rd); end
            advance();
        end
        @(negedge clock); idle();
        alu_wb_valid = 1; alu_wb_rd = 5'd0; alu_wb_data = 32'hDEADBEEF;
        set_mem(5'd9, 32'h99);
        #1;
        n_vec++; if (rf_regWrite !== 1'b0 || rf_rd !== 5'd9 || rf_writeData !== 32'h99) begin n_err++; $display("FAIL x0_alu_mem: got we %b rd %0d data %h want 0/9/99", rf_regWrite, rf_rd, rf_writeData); end
        advance();
        @(negedge clock); idle();
        set_mem(5'd0, 32'h77);
        #1;
        n_vec++; if (rf_regWrite !== 1'b1) begin n_err++; $display("FAIL x0_mem: got we %b want 1", rf_regWrite); end
        advance();
        @(negedge clock); idle(); #1;
        n_vec++; if (outstanding !== 3'd0 || mem_wb_ready !== 1'b1) begin n_err++; $display("FAIL x0_after: got cnt %0d ready %b want 0/1", outstanding, mem_wb_ready); end
        advance();
    endtask

    task automatic test_collision();
        @(negedge clock); idle(); set_issue(5'd1, 5'd2, 5'd7, 1'b1); #1;
        n_vec++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL col_issue: got %b want 0", issue_stall); end
        advance();
        @(negedge clock); idle();
        alu_wb_valid = 1; alu_wb_rd = 5'd6; alu_wb_data = 32'h11;
        set_mem(5'd7, 32'h22);
        #1;
        n_vec++; if (rf_regWrite !== 1'b0 || rf_rd !== 5'd6 || rf_writeData !== 32'h11 || mem_wb_ready !== 1'b1) begin n_err++; $display("FAIL col_c0: got we %b rd %0d data %h ready %b want 0/6/11/1", rf_regWrite, rf_rd, rf_writeData, mem_wb_ready); end
        advance();
        @(negedge clock); idle(); #1;
        n_vec++; if (rf_regWrite !== 1'b0 || rf_rd !== 5'd7 || rf_writeData !== 32'h22 || mem_wb_ready !== 1'b0) begin n_err++; $display("FAIL col_c1: got we %b rd %0d data %h ready %b want 0/7/22/0", rf_regWrite, rf_rd, rf_writeData, mem_wb_ready); end
        n_vec++; if (busy_mask[7] !== 1'b1) begin n_err++; $display("FAIL col_busy_held: got %b want 1", busy_mask[7]); end
        advance();
        @(negedge clock); idle(); #1;
        n_vec++; if (mem_wb_ready !== 1'b1 || busy_mask !== 32'd0 || outstanding !== 3'd0 || rf_regWrite !== 1'b1) begin n_err++; $display("FAIL col_c2: got ready %b busy %h cnt %0d we %b want 1/0/0/1", mem_wb_ready, busy_mask, outstanding, rf_regWrite); end
        advance();
    endtask

    task automatic test_raw_stall();
        @(negedge clock); idle(); set_issue(5'd0, 5'd0, 5'd10, 1'b1); advance();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); idle(); set_issue(5'd10, 5'd0, 5'd1, 1'b0); #1;
            n_vec++; if (issue_stall !== 1'b1) begin n_err++; $display("FAIL raw_hold%0d: got %b want 1", i, issue_stall); end
            advance();
        end
        @(negedge clock); idle(); set_issue(5'd10, 5'd0, 5'd1, 1'b0); set_mem(5'd10, 32'hA); #1;
        n_vec++; if (issue_stall !== 1'b1 || rf_rd !== 5'd10 || rf_regWrite !== 1'b0) begin n_err++; $display("FAIL raw_commit: got stall %b rd %0d we %b want 1/10/0", issue_stall, rf_rd, rf_regWrite); end
        advance();
        @(negedge clock); idle(); set_issue(5'd10, 5'd0, 5'd1, 1'b0); #1;
        n_vec++; if (issue_stall !== 1'b0 || busy_mask !== 32'd0) begin n_err++; $display("FAIL raw_release: got stall %b busy %h want 0/0", issue_stall, busy_mask); end
        advance();
    endtask

    task automatic test_counter_limit();
        for (int r = 11; r <= 14; r++) begin
            @(negedge clock); idle(); set_issue(5'd0, 5'd0, 5'(r), 1'b1); #1;
            n_vec++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL lim_acc_x%0d: got %b want 0", r, issue_stall); end
            advance();
        end
        @(negedge clock); idle(); set_issue(5'd0, 5'd0, 5'd16, 1'b1); #1;
        n_vec++; if (issue_stall !== 1'b1 || outstanding !== 3'd4) begin n_err++; $display("FAIL lim_full: got stall %b cnt %0d want 1/4", issue_stall, outstanding); end
        advance();
        @(negedge clock); idle(); set_issue(5'd1, 5'd2, 5'd15, 1'b0); #1;
        n_vec++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL lim_short: got %b want 0", issue_stall); end
        advance();
        @(negedge clock); idle(); set_issue(5'd0, 5'd0, 5'd16, 1'b1); set_mem(5'd14, 32'h14); #1;
        n_vec++; if (issue_stall !== 1'b1) begin n_err++; $display("FAIL lim_ret_cycle: got %b want 1", issue_stall); end
        advance();
        @(negedge clock); idle(); set_issue(5'd0, 5'd0, 5'd16, 1'b1); #1;
        n_vec++; if (issue_stall !== 1'b0 || outstanding !== 3'd3) begin n_err++; $display("FAIL lim_5th: got stall %b cnt %0d want 0/3", issue_stall, outstanding); end
        advance();
        @(negedge clock); idle(); set_mem(5'd13, 32'h13); advance();
        // Commit x11 and accept a long issue to x20 in the same cycle.
        @(negedge clock); idle(); set_mem(5'd11, 32'h11); set_issue(5'd0, 5'd0, 5'd20, 1'b1); #1;
        n_vec++; if (issue_stall !== 1'b0 || outstanding !== 3'd3) begin n_err++; $display("FAIL same_pre: got stall %b cnt %0d want 0/3", issue_stall, outstanding); end
        advance();
        @(negedge clock); idle(); #1;
        n_vec++; if (outstanding !== 3'd3 || busy_mask[11] !== 1'b0 || busy_mask[20] !== 1'b1) begin n_err++; $display("FAIL same_post: got cnt %0d b11 %b b20 %b want 3/0/1", outstanding, busy_mask[11], busy_mask[20]); end
        advance();
        for (int r = 0; r < 3; r++) begin
            @(negedge clock); idle();
            set_mem(r == 0 ? 5'd12 : (r == 1 ? 5'd16 : 5'd20), 32'(r));
            advance();
        end
        @(negedge clock); idle(); #1;
        n_vec++; if (outstanding !== 3'd0 || busy_mask !== 32'd0) begin n_err++; $display("FAIL lim_drain: got cnt %0d busy %h want 0/0", outstanding, busy_mask); end
        advance();
    endtask

    task automatic test_reset_mid();
        @(negedge clock); idle(); set_issue(5'd0, 5'd0, 5'd5, 1'b1); advance();
        @(negedge clock); idle(); set_issue(5'd0, 5'd0, 5'd8, 1'b1); advance();
        @(negedge clock); idle();
        alu_wb_valid = 1; alu_wb_rd = 5'd3; alu_wb_data = 32'h33;
        set_mem(5'd8, 32'h88);
        advance();
        @(negedge clock); idle(); #1;
        n_vec++; if (mem_wb_ready !== 1'b0 || outstanding !== 3'd2 || busy_mask[5] !== 1'b1) begin n_err++; $display("FAIL mid_pre: got ready %b cnt %0d b5 %b want 0/2/1", mem_wb_ready, outstanding, busy_mask[5]); end
        reset = 1;
        model_reset();
        #1;
        n_vec++; if (rf_regWrite !== 1'b1 || busy_mask !== 32'd0 || outstanding !== 3'd0 || issue_stall !== 1'b1) begin n_err++; $display("FAIL mid_rst: got we %b busy %h cnt %0d stall %b want 1/0/0/1", rf_regWrite, busy_mask, outstanding, issue_stall); end
        @(negedge clock);
        reset = 0;
        set_mem(5'd5, 32'h55);
        #1;
        n_vec++; if (rf_regWrite !== 1'b0 || rf_rd !== 5'd5 || rf_writeData !== 32'h55) begin n_err++; $display("FAIL mid_stale: got we %b rd %0d data %h want 0/5/55", rf_regWrite, rf_rd, rf_writeData); end
        advance();
        @(negedge clock); idle(); #1;
        n_vec++; if (outstanding !== 3'd0 || mem_wb_ready !== 1'b1) begin n_err++; $display("FAIL mid_after: got cnt %0d ready %b want 0/1", outstanding, mem_wb_ready); end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clock); idle();
            if ($urandom_range(0, 2) == 0) begin
                alu_wb_valid = 1; alu_wb_rd = 5'($urandom_range(0, 31)); alu_wb_data = $urandom;
            end
            if ($urandom_range(0, 1) == 0) begin
                mem_wb_valid = 1; mem_wb_rd = 5'($urandom_range(0, 9)); mem_wb_data = $urandom;
            end
            if ($urandom_range(0, 1) == 0) begin
                set_issue(5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
                          5'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
            end
            #1;
            predict();
            n_vec++; if (rf_regWrite !== e_regwrite || rf_rd !== e_rd || rf_writeData !== e_data) begin n_err++; $display("FAIL rnd_port@%0d: got %b/%0d/%h want %b/%0d/%h", c, rf_regWrite, rf_rd, rf_writeData, e_regwrite, e_rd, e_data); end
            n_vec++; if (mem_wb_ready !== e_ready || issue_stall !== e_stall) begin n_err++; $display("FAIL rnd_hs@%0d: got ready %b stall %b want %b/%b", c, mem_wb_ready, issue_stall, e_ready, e_stall); end
            n_vec++; if (busy_mask !== m_busy || outstanding !== 3'(m_cnt)) begin n_err++; $display("FAIL rnd_state@%0d: got %h/%0d want %h/%0d", c, busy_mask, outstanding, m_busy, m_cnt); end
            advance();
        end
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_x0_suppress();
        test_collision();
        test_raw_stall();
        test_counter_limit();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
